// File: rtl/xif_copro_alu_pkg.sv
// Shared types and the single-cycle ALU function for the custom-0 XIF coprocessor.
package xif_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    // Buffer entries store ids zero-extended to this width, so X_ID_WIDTH may be up to 8.
    localparam int ID_W_MAX = 8;

    typedef enum logic [2:0] {
        OP_SADD    = 3'd0,
        OP_MIN     = 3'd1,
        OP_MAX     = 3'd2,
        OP_ABSDIFF = 3'd3,
        OP_MULLO   = 3'd4
    } copro_op_e;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        copro_op_e           op;
        logic [4:0]          rd;
        logic [31:0]         rs1;
        logic [31:0]         rs2;
        logic                committed;
        logic                killed;
        logic                valid;
    } copro_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } copro_state_e;

    // Results of the ops that finish in one cycle; MULLO is handled by the serial multiplier.
    function automatic logic [31:0] alu_single(input copro_op_e op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [32:0] sum;
        logic [31:0] res;
        sum = {a[31], a} + {b[31], b};
        res = '0;
        case (op)
            OP_SADD: begin
                // The two top bits of the sign-extended sum disagree only on overflow.
                if (sum[32] != sum[31]) res = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                else                    res = sum[31:0];
            end
            OP_MIN:     res = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:     res = ($signed(a) > $signed(b)) ? a : b;
            OP_ABSDIFF: res = (a >= b) ? (a - b) : (b - a);
            default:    res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/xif_copro_mul_serial.sv
// Shift-add 32x32 multiplier returning the low word, one multiplier bit per cycle.
// done is asserted during the 32nd step; product then already includes that step.
module xif_copro_mul_serial (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic [31:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
    assign done     = busy && (cnt == 6'd1);
    assign product  = acc_next;

    // Load operands on start, then retire one multiplier bit per cycle down to terminal count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= 6'd32;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 6'd1;
            if (cnt == 6'd1) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/xif_copro_alu.sv
// Custom-0 XIF coprocessor: buffers issued instructions until commit/kill and
// executes them in issue order, returning rd through the result interface.
//
//  state  | meaning
//  S_IDLE | waiting for the head entry to be committed
//  S_BUSY | serial multiply in progress for the head entry
//  S_RESP | result offered; head is popped when the core takes it
module xif_copro_alu
    import xif_copro_pkg::*;
#(
    parameter int         X_ID_WIDTH  = 4,
    parameter int         X_NUM_RS    = 2,
    parameter int         X_RFR_WIDTH = 32,
    parameter int         DEPTH       = 4,
    parameter logic [6:0] OPCODE      = OPCODE_CUSTOM0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            compressed_valid,
    output logic                            compressed_ready,
    output logic                            compressed_resp_accept,
    output logic [31:0]                     compressed_resp_instr,
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [31:0]                     issue_req_instr,
    input  logic [X_ID_WIDTH-1:0]           issue_req_id,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_req_rs,
    input  logic [X_NUM_RS-1:0]             issue_req_rs_valid,
    output logic                            issue_resp_accept,
    output logic                            issue_resp_writeback,
    output logic                            issue_resp_dualwrite,
    output logic                            issue_resp_dualread,
    output logic [2:0]                      issue_resp_loadstore,
    output logic                            issue_resp_ecswrite,
    output logic                            issue_resp_exc,
    input  logic                            commit_valid,
    input  logic [X_ID_WIDTH-1:0]           commit_id,
    input  logic                            commit_kill,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [X_ID_WIDTH-1:0]           result_id,
    output logic [31:0]                     result_data,
    output logic [4:0]                      result_rd,
    output logic                            result_we,
    output logic [5:0]                      result_ecsdata,
    output logic [2:0]                      result_ecswe,
    output logic                            result_exc,
    output logic [5:0]                      result_exccode,
    output logic                            result_err,
    output logic                            result_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    copro_entry_t entries   [DEPTH];
    copro_entry_t entries_n [DEPTH];
    copro_entry_t head;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;

    copro_state_e state, state_n;

    logic [2:0]          funct3;
    logic                cand;
    logic                push;
    logic                pop;
    logic [ID_W_MAX-1:0] commit_id_ext;
    logic [ID_W_MAX-1:0] issue_id_ext;

    logic        mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    logic        res_load;
    logic [31:0] res_data_n;

    logic unused_inputs;
    assign unused_inputs = ^{compressed_valid, issue_req_instr[24:15], mul_busy};

    assign compressed_ready       = 1'b1;
    assign compressed_resp_accept = 1'b0;
    assign compressed_resp_instr  = '0;

    assign funct3 = issue_req_instr[14:12];
    assign cand   = (issue_req_instr[6:0] == OPCODE) && (issue_req_instr[31:25] == 7'd0)
                    && (funct3 <= 3'd4);

    assign full        = (count == CNT_W'(DEPTH));
    // Ready ignores a pop in the same cycle, keeping the handshake off the FSM path.
    assign issue_ready = !full && (!cand || (issue_req_rs_valid[1:0] == 2'b11));

    assign issue_resp_accept    = issue_valid && cand;
    assign issue_resp_writeback = issue_valid && cand;
    assign issue_resp_dualwrite = 1'b0;
    assign issue_resp_dualread  = 1'b0;
    assign issue_resp_loadstore = '0;
    assign issue_resp_ecswrite  = 1'b0;
    assign issue_resp_exc       = 1'b0;

    assign push          = issue_valid && issue_ready && cand;
    assign commit_id_ext = ID_W_MAX'(commit_id);
    assign issue_id_ext  = ID_W_MAX'(issue_req_id);
    assign head          = entries[rd_ptr];

    // Next buffer contents: retire head, write new entry, then apply commit so a
    // commit can hit the entry being pushed in the same cycle.
    always_comb begin
        entries_n = entries;
        if (pop) entries_n[rd_ptr].valid = 1'b0;
        if (push) begin
            entries_n[wr_ptr].id        = issue_id_ext;
            entries_n[wr_ptr].op        = copro_op_e'(funct3);
            entries_n[wr_ptr].rd        = issue_req_instr[11:7];
            entries_n[wr_ptr].rs1       = issue_req_rs[31:0];
            entries_n[wr_ptr].rs2       = issue_req_rs[63:32];
            entries_n[wr_ptr].committed = 1'b0;
            entries_n[wr_ptr].killed    = 1'b0;
            entries_n[wr_ptr].valid     = 1'b1;
        end
        if (commit_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_n[i].valid && (entries_n[i].id == commit_id_ext)) begin
                    entries_n[i].committed = 1'b1;
                    if (commit_kill) entries_n[i].killed = 1'b1;
                end
            end
        end
    end

    // Buffer storage, circular pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            entries <= entries_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state, pop and execute decisions for the head entry.
    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        mul_start  = 1'b0;
        res_load   = 1'b0;
        res_data_n = '0;
        case (state)
            S_IDLE: begin
                if (head.valid && head.committed) begin
                    if (head.killed) begin
                        pop = 1'b1;
                    end else if (head.op == OP_MULLO) begin
                        mul_start = 1'b1;
                        state_n   = S_BUSY;
                    end else begin
                        res_load   = 1'b1;
                        res_data_n = alu_single(head.op, head.rs1, head.rs2);
                        state_n    = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    res_load   = 1'b1;
                    res_data_n = mul_product;
                    state_n    = S_RESP;
                end
            end
            S_RESP: begin
                if (result_ready) begin
                    pop     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Result fields are captured once and held stable while offered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_id   <= '0;
            result_data <= '0;
            result_rd   <= '0;
        end else if (res_load) begin
            result_id   <= head.id[X_ID_WIDTH-1:0];
            result_data <= res_data_n;
            result_rd   <= head.rd;
        end
    end

    assign result_valid   = (state == S_RESP);
    assign result_we      = result_valid;
    assign result_ecsdata = '0;
    assign result_ecswe   = '0;
    assign result_exc     = 1'b0;
    assign result_exccode = '0;
    assign result_err     = 1'b0;
    assign result_dbg     = 1'b0;

    xif_copro_mul_serial u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start   (mul_start),
        .op_a    (head.rs1),
        .op_b    (head.rs2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_xif_copro_alu.sv
// Directed bench for xif_copro_alu; inputs driven and outputs sampled 1ns after posedge.
module tb_xif_copro_alu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        compressed_valid = 1'b0;
    logic        compressed_ready, compressed_resp_accept;
    logic [31:0] compressed_resp_instr;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [31:0] issue_req_instr = '0;
    logic [3:0]  issue_req_id = '0;
    logic [63:0] issue_req_rs = '0;
    logic [1:0]  issue_req_rs_valid = '0;
    logic        issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite;
    logic        issue_resp_dualread, issue_resp_ecswrite, issue_resp_exc;
    logic [2:0]  issue_resp_loadstore;
    logic        commit_valid = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        commit_kill = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [5:0]  result_ecsdata, result_exccode;
    logic [2:0]  result_ecswe;
    logic        result_exc, result_err, result_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    xif_copro_alu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .compressed_valid(compressed_valid), .compressed_ready(compressed_ready),
        .compressed_resp_accept(compressed_resp_accept), .compressed_resp_instr(compressed_resp_instr),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_req_instr(issue_req_instr),
        .issue_req_id(issue_req_id), .issue_req_rs(issue_req_rs), .issue_req_rs_valid(issue_req_rs_valid),
        .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
        .issue_resp_dualwrite(issue_resp_dualwrite), .issue_resp_dualread(issue_resp_dualread),
        .issue_resp_loadstore(issue_resp_loadstore), .issue_resp_ecswrite(issue_resp_ecswrite),
        .issue_resp_exc(issue_resp_exc),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
        .result_ecsdata(result_ecsdata), .result_ecswe(result_ecswe), .result_exc(result_exc),
        .result_exccode(result_exccode), .result_err(result_err), .result_dbg(result_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rinstr(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0, 5'd2, 5'd1, f3, rd, 7'b0001011};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one instruction, check the accept decision, hold until handshake (bounded).
    task automatic do_issue(input string tag, input logic [31:0] instr, input logic [3:0] id,
                            input logic [31:0] a, input logic [31:0] b, input logic exp_acc);
        int n;
        issue_req_instr    = instr;
        issue_req_id       = id;
        issue_req_rs       = {b, a};
        issue_req_rs_valid = 2'b11;
        issue_valid        = 1'b1;
        #1;
        check({tag, "_accept"}, 32'(issue_resp_accept), 32'(exp_acc));
        check({tag, "_writeback"}, 32'(issue_resp_writeback), 32'(exp_acc));
        n = 0;
        while (!issue_ready && n < 20) begin
            tick();
            n++;
        end
        if (!issue_ready) begin
            check({tag, "_ready_timeout"}, 32'(issue_ready), 32'd1);
        end else begin
            tick();
        end
        issue_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    // Wait (bounded) for a result, check its fields, then take it.
    task automatic get_result(input string tag, input logic [3:0] id, input logic [31:0] data,
                              input logic [4:0] rd);
        int n;
        n = 0;
        while (!result_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        if (result_valid) begin
            check({tag, "_id"}, 32'(result_id), 32'(id));
            check({tag, "_data"}, result_data, data);
            check({tag, "_rd"}, 32'(result_rd), 32'(rd));
            check({tag, "_we"}, 32'(result_we), 32'd1);
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
        end
    endtask

    initial begin
        int n;
        int seen;

        // Reset state
        #12;
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result_data", result_data, 32'd0);
        check("rst_result_id", 32'(result_id), 32'd0);
        check("rst_compressed", {29'd0, compressed_ready, compressed_resp_accept, 1'b0}, 32'h4);
        rst_ni = 1'b1;
        tick();

        // 1: saturating add, result one cycle after commit
        do_issue("t1", rinstr(3'd0, 5'd5), 4'd3, 32'h7FFF_FFF0, 32'h0000_0020, 1'b1);
        do_commit(4'd3, 1'b0);
        check("t1_not_yet", 32'(result_valid), 32'd0);
        tick();
        check("t1_one_cycle", 32'(result_valid), 32'd1);
        get_result("t1", 4'd3, 32'h7FFF_FFFF, 5'd5);
        check("t1_popped", 32'(result_valid), 32'd0);

        // 2: MULLO takes 33 cycles from commit
        do_issue("t2", rinstr(3'd4, 5'd7), 4'd4, 32'h0001_0001, 32'h0000_FFFF, 1'b1);
        do_commit(4'd4, 1'b0);
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        check("t2_latency", 32'(n), 32'd33);
        get_result("t2", 4'd4, 32'hFFFF_FFFF, 5'd7);

        // 3: MIN / MAX(killed) / ABSDIFF
        do_issue("t3a", rinstr(3'd1, 5'd1), 4'd1, 32'hFFFF_FFFB, 32'd3, 1'b1);
        do_issue("t3b", rinstr(3'd2, 5'd2), 4'd2, 32'hFFFF_FFFB, 32'd3, 1'b1);
        do_issue("t3c", rinstr(3'd3, 5'd3), 4'd3, 32'd5, 32'hFFFF_FFFF, 1'b1);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b1);
        do_commit(4'd3, 1'b0);
        get_result("t3_min", 4'd1, 32'hFFFF_FFFB, 5'd1);
        get_result("t3_absdiff", 4'd3, 32'hFFFF_FFFA, 5'd3);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid) seen++;
        end
        check("t3_no_extra", 32'(seen), 32'd0);

        // 4: fill buffer, full blocks issue, pop frees a slot
        do_issue("t4_5", rinstr(3'd0, 5'd5), 4'd5, 32'd5, 32'h100, 1'b1);
        do_issue("t4_6", rinstr(3'd0, 5'd6), 4'd6, 32'd6, 32'h100, 1'b1);
        do_issue("t4_7", rinstr(3'd0, 5'd7), 4'd7, 32'd7, 32'h100, 1'b1);
        do_issue("t4_8", rinstr(3'd0, 5'd8), 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue_req_instr    = rinstr(3'd0, 5'd9);
        issue_req_id       = 4'd9;
        issue_req_rs       = {32'h100, 32'd9};
        issue_req_rs_valid = 2'b11;
        issue_valid        = 1'b1;
        #1;
        check("t4_full_ready", 32'(issue_ready), 32'd0);
        result_ready = 1'b1;
        do_commit(4'd5, 1'b0);
        n = 0;
        while (!issue_ready && n < 10) begin
            tick();
            n++;
        end
        check("t4_ready_after_pop", 32'(issue_ready), 32'd1);
        tick();
        issue_valid  = 1'b0;
        result_ready = 1'b0;
        do_commit(4'd6, 1'b0);
        do_commit(4'd7, 1'b0);
        do_commit(4'd8, 1'b0);
        do_commit(4'd9, 1'b0);
        get_result("t4_6", 4'd6, 32'h106, 5'd6);
        get_result("t4_7", 4'd7, 32'h107, 5'd7);
        get_result("t4_8", 4'd8, 32'h8000_0000, 5'd8);
        get_result("t4_9", 4'd9, 32'h109, 5'd9);

        // 5: non-claimed instruction, operand-valid gating
        do_issue("t5", {7'b0, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011}, 4'd10, 32'd1, 32'd2, 1'b0);
        do_commit(4'd10, 1'b0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result_valid) seen++;
        end
        check("t5_no_result", 32'(seen), 32'd0);
        issue_req_instr    = rinstr(3'd0, 5'd1);
        issue_req_rs_valid = 2'b01;
        issue_valid        = 1'b1;
        #1;
        check("t5_rs_valid_gate", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        tick();

        // 6: stall stability, then reset in the middle of a multiply
        do_issue("t6", rinstr(3'd1, 5'd11), 4'd11, 32'd20, 32'd30, 1'b1);
        do_commit(4'd11, 1'b0);
        tick();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(result_valid && result_id == 4'd11 && result_data == 32'd20 && result_rd == 5'd11))
                seen++;
        end
        check("t6_stall_stable", 32'(seen), 32'd0);
        get_result("t6", 4'd11, 32'd20, 5'd11);
        do_issue("t6_mul", rinstr(3'd4, 5'd12), 4'd12, 32'd3, 32'd4, 1'b1);
        do_commit(4'd12, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        rst_ni = 1'b0;
        #1;
        check("t6_rst_result_valid", 32'(result_valid), 32'd0);
        check("t6_rst_issue_ready", 32'(issue_ready), 32'd1);
        #3;
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid) seen++;
        end
        check("t6_no_result_after_rst", 32'(seen), 32'd0);
        do_issue("t6_e1", rinstr(3'd0, 5'd1), 4'd1, 32'd1, 32'd1, 1'b1);
        do_issue("t6_e2", rinstr(3'd0, 5'd2), 4'd2, 32'd1, 32'd1, 1'b1);
        do_issue("t6_e3", rinstr(3'd0, 5'd3), 4'd3, 32'd1, 32'd1, 1'b1);
        do_issue("t6_e4", rinstr(3'd0, 5'd4), 4'd4, 32'd1, 32'd1, 1'b1);
        issue_req_instr = rinstr(3'd0, 5'd5);
        issue_req_id    = 4'd5;
        issue_valid     = 1'b1;
        #1;
        check("t6_empty_then_full", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
